// File: rtl/msg_pkg.sv
// Shared types and constants for the scrolling 4-digit message display.
package msg_pkg;
  typedef enum logic [1:0] {ST_LOAD, ST_SHOW, ST_SCROLL} state_e;

  localparam int CODE_W     = 5;
  localparam int NUM_DIGITS = 4;
  localparam logic [CODE_W-1:0] PAD_CODE = '0;
  localparam int HOLD_CODE  = 32;
endpackage

// File: rtl/tick_gen.sv
// Free-running divider: counts 0..DIV-1 and pulses tick for the cycle at DIV-1.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/msg_scroller.sv
// Message buffer plus scrolling 4-digit window, multiplexed onto one
// code bus with active-low digit enables.
module msg_scroller
  import msg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int SCROLL_DIV  = 50000000,
  parameter int MSG_DEPTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [4:0]                 wr_data,
  output logic                       wr_ready,
  input  logic                       clear,
  input  logic                       start,
  input  logic                       stop,
  output logic [4:0]                 code,
  output logic [3:0]                 an,
  output logic [$clog2(MSG_DEPTH):0] msg_len
);
  localparam int AW = $clog2(MSG_DEPTH);
  localparam int LW = AW + 1;
  // offset reaches msg_len+3 and the read ports add up to 3 more
  localparam int OW = AW + 2;

  state_e                               state_q, state_d;
  logic [LW-1:0]                        len_q, len_d;
  logic [OW-1:0]                        off_q, off_d;
  logic [1:0]                           digit_q, digit_d;
  logic [CODE_W-1:0]                    code_q, code_d;
  logic [3:0]                           an_q, an_d;
  logic [MSG_DEPTH-1:0][CODE_W-1:0]     mem_q, mem_d;
  logic [NUM_DIGITS-1:0][CODE_W-1:0]    win;
  logic                                 refresh_tick, scroll_tick, write_ok;

  tick_gen #(.DIV(REFRESH_DIV)) u_refresh (.clk(clk), .rst(rst), .tick(refresh_tick));
  tick_gen #(.DIV(SCROLL_DIV))  u_scroll  (.clk(clk), .rst(rst), .tick(scroll_tick));

  assign wr_ready = (state_q == ST_LOAD) && (len_q != LW'(MSG_DEPTH));
  assign write_ok = wr_en && wr_ready && !clear;
  assign msg_len  = len_q;
  assign code     = code_q;
  assign an       = an_q;

  // Four combinational read ports; indices past the message read as pad.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_rd
    logic [OW-1:0] vidx;
    assign vidx   = off_q + OW'(i);
    assign win[i] = (vidx < OW'(len_q)) ? mem_q[vidx[AW-1:0]] : PAD_CODE;
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    off_d   = off_q;
    mem_d   = mem_q;
    if (clear) begin
      state_d = ST_LOAD;
      len_d   = '0;
      off_d   = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (write_ok) begin
            mem_d[len_q[AW-1:0]] = wr_data;
            len_d                = len_q + LW'(1);
          end
          if (start && (len_q != '0)) state_d = ST_SCROLL;
        end
        ST_SCROLL: begin
          if (stop) state_d = ST_SHOW;
          else if (scroll_tick)
            off_d = (off_q == OW'(len_q) + OW'(3)) ? '0 : off_q + OW'(1);
        end
        ST_SHOW: begin
          if (start && !stop) state_d = ST_SCROLL;
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  // code and an load together so a digit never shows a stale letter
  always_comb begin
    digit_d = digit_q;
    code_d  = code_q;
    an_d    = an_q;
    if (refresh_tick) begin
      code_d  = win[digit_q];
      an_d    = ~(4'b1000 >> digit_q);
      digit_d = digit_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
      len_q   <= '0;
      off_q   <= '0;
      digit_q <= '0;
      code_q  <= '0;
      an_q    <= 4'b1111;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      off_q   <= off_d;
      digit_q <= digit_d;
      code_q  <= code_d;
      an_q    <= an_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule
